// File: rtl/mac_accum_seq.sv
// Accumulating sequencer behind the mac ALU: registers and saturates mac.out and feeds it back as preResult.
// Result valid 1 cycle after the last term (or after a zero-length start); held under out_ready=0 backpressure.
module mac_accum_seq #(
    parameter int LEN   = 8,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               start,
    input  logic [CNT_W-1:0]   acc_len,
    input  logic               abort,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2*LEN-1:0]   mac_out,
    output logic [LEN-1:0]     pre_result,
    output logic [LEN-1:0]     result,
    output logic               result_valid,
    input  logic               out_ready,
    output logic               sat_flag,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Clamp bounds, sign-extended to the full mac output width.
    localparam logic signed [2*LEN-1:0] SAT_MAX = {{(LEN+1){1'b0}}, {(LEN-1){1'b1}}};
    localparam logic signed [2*LEN-1:0] SAT_MIN = {{(LEN+1){1'b1}}, {(LEN-1){1'b0}}};

    state_t             state;
    logic [LEN-1:0]     acc;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   len_q;

    logic signed [2*LEN-1:0] mac_s;
    logic [LEN-1:0]          sat_val;
    logic                    sat_hit;
    logic                    beat;

    assign mac_s = $signed(mac_out);

    always_comb begin
        sat_val = mac_out[LEN-1:0];
        sat_hit = 1'b0;
        if (mac_s > SAT_MAX) begin
            sat_val = SAT_MAX[LEN-1:0];
            sat_hit = 1'b1;
        end else if (mac_s < SAT_MIN) begin
            sat_val = SAT_MIN[LEN-1:0];
            sat_hit = 1'b1;
        end
    end

    assign beat = in_valid && (state == ACC);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            acc      <= '0;
            cnt      <= '0;
            len_q    <= '0;
            sat_flag <= 1'b0;
        end else if (abort) begin
            state    <= IDLE;
            acc      <= '0;
            cnt      <= '0;
            sat_flag <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        len_q    <= acc_len;
                        acc      <= '0;
                        cnt      <= '0;
                        sat_flag <= 1'b0;
                        state    <= (acc_len == '0) ? DONE : ACC;
                    end
                end
                ACC: begin
                    if (beat) begin
                        acc      <= sat_val;
                        cnt      <= cnt + CNT_W'(1);
                        sat_flag <= sat_flag | sat_hit;
                        if (cnt == len_q - CNT_W'(1)) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    // acc is kept so result stays readable until the next start.
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // pre_result comes straight from the register, breaking the mac feedback loop.
    assign pre_result   = acc;
    assign result       = acc;
    assign in_ready     = (state == ACC);
    assign result_valid = (state == DONE);
    assign busy         = (state != IDLE);

endmodule

// File: tb/tb_mac_accum_seq.sv
// Bench for mac_accum_seq: models mac as in1*in2 + pre_result and checks against an integer accumulator model.
module tb_mac_accum_seq;

    localparam int LEN   = 8;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             start = 1'b0;
    logic [CNT_W-1:0] acc_len = '0;
    logic             abort = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [15:0]      mac_out;
    logic [7:0]       pre_result;
    logic [7:0]       result;
    logic             result_valid;
    logic             out_ready = 1'b0;
    logic             sat_flag;
    logic             busy;

    logic signed [7:0] op_a = '0;
    logic signed [7:0] op_b = '0;

    int checks = 0;
    int errors = 0;
    int m_acc  = 0;
    bit m_sat  = 0;

    always #5 clk = ~clk;

    // Behavioural mac: product plus fed-back accumulator, all sign-extended to 16 bits.
    assign mac_out = $signed({{8{op_a[7]}}, op_a}) * $signed({{8{op_b[7]}}, op_b})
                   + $signed({{8{pre_result[7]}}, pre_result});

    mac_accum_seq #(.LEN(LEN), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .start        (start),
        .acc_len      (acc_len),
        .abort        (abort),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .mac_out      (mac_out),
        .pre_result   (pre_result),
        .result       (result),
        .result_valid (result_valid),
        .out_ready    (out_ready),
        .sat_flag     (sat_flag),
        .busy         (busy)
    );

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        m_acc = 0;
        m_sat = 0;
    endtask

    task automatic begin_run(input int len);
        start   = 1'b1;
        acc_len = CNT_W'(len);
        tick();
        start   = 1'b0;
        acc_len = CNT_W'($urandom);
        model_clear();
        chk("busy_after_start", busy, 1);
        chk("in_ready_after_start", in_ready, (len != 0) ? 1 : 0);
    endtask

    task automatic beat(input int a, input int b);
        int s;
        op_a     = 8'(a);
        op_b     = 8'(b);
        in_valid = 1'b1;
        chk("in_ready_beat", in_ready, 1);
        tick();
        in_valid = 1'b0;
        s = a * b + m_acc;
        if (s > 127) begin
            s = 127;
            m_sat = 1;
        end else if (s < -128) begin
            s = -128;
            m_sat = 1;
        end
        m_acc = s;
        chk("pre_result", $signed(pre_result), m_acc);
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) begin
            op_a = 8'($urandom);
            op_b = 8'($urandom);
            tick();
            chk("pre_result_hold", $signed(pre_result), m_acc);
            chk("in_ready_gap", in_ready, 1);
        end
    endtask

    task automatic finish_run(input int hold);
        chk("result_valid", result_valid, 1);
        chk("result", $signed(result), m_acc);
        chk("sat_flag", sat_flag, m_sat);
        chk("in_ready_done", in_ready, 0);
        for (int i = 0; i < hold; i++) begin
            start   = 1'b1;
            acc_len = 8'd1;
            tick();
            chk("result_hold", $signed(result), m_acc);
            chk("result_valid_hold", result_valid, 1);
            chk("sat_flag_hold", sat_flag, m_sat);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        start     = 1'b0;
        chk("busy_after_out", busy, 0);
        chk("result_valid_after_out", result_valid, 0);
        tick();
        chk("idle_stays", busy, 0);
    endtask

    initial begin
        int len;
        #12;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_result_valid", result_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pre_result", $signed(pre_result), 0);
        chk("rst_result", $signed(result), 0);
        chk("rst_sat_flag", sat_flag, 0);
        rstn = 1'b1;
        tick();

        // basic dot product
        begin_run(3);
        beat(2, 3);
        chk("basic_pre0", $signed(pre_result), 6);
        beat(4, 5);
        chk("basic_pre1", $signed(pre_result), 26);
        beat(-1, 6);
        chk("basic_pre2", $signed(pre_result), 20);
        chk("basic_result", $signed(result), 20);
        finish_run(0);

        // positive saturation, then negative
        begin_run(2);
        beat(10, 10);
        chk("sat_pre0", $signed(pre_result), 100);
        beat(10, 10);
        chk("sat_pos_result", $signed(result), 127);
        chk("sat_pos_flag", sat_flag, 1);
        finish_run(0);
        begin_run(1);
        chk("sat_flag_cleared", sat_flag, 0);
        beat(-10, 13);
        chk("sat_neg_result", $signed(result), -128);
        chk("sat_neg_flag", sat_flag, 1);
        finish_run(0);

        // zero-length run
        begin_run(0);
        chk("zero_result_valid", result_valid, 1);
        chk("zero_result", $signed(result), 0);
        finish_run(1);

        // handshake: gaps, back-pressured result, start pulses in DONE
        begin_run(4);
        for (int i = 0; i < 4; i++) begin
            gap(i + 1);
            beat($signed(8'($urandom)) % 12, $signed(8'($urandom)) % 12);
        end
        finish_run(5);

        // abort after 2 of 4 terms
        begin_run(4);
        beat(3, 4);
        beat(5, 6);
        abort = 1'b1;
        in_valid = 1'b1;
        out_ready = 1'b1;
        tick();
        abort = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        model_clear();
        chk("abort_busy", busy, 0);
        chk("abort_pre_result", $signed(pre_result), 0);
        chk("abort_result_valid", result_valid, 0);
        chk("abort_sat_flag", sat_flag, 0);
        tick();
        chk("abort_no_result", result_valid, 0);

        // async reset mid-ACC
        begin_run(4);
        beat(7, 7);
        #2;
        rstn = 1'b0;
        #1;
        chk("arst_in_ready", in_ready, 0);
        chk("arst_busy", busy, 0);
        chk("arst_pre_result", $signed(pre_result), 0);
        chk("arst_result", $signed(result), 0);
        chk("arst_result_valid", result_valid, 0);
        #2;
        rstn = 1'b1;
        tick();
        begin_run(1);
        beat(3, 3);
        chk("fresh_result", $signed(result), 9);
        finish_run(0);

        // randomized runs against the integer model
        for (int r = 0; r < 25; r++) begin
            len = $urandom_range(1, 7);
            begin_run(len);
            for (int t = 0; t < len; t++) begin
                gap($urandom_range(0, 2));
                beat($signed(8'($urandom)), $signed(8'($urandom_range(0, 255))) % 8);
            end
            finish_run($urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout: observed no completion expected finish");
        $fatal(1, "timeout");
    end

endmodule
